par2ser_mux_ctrl: RTL and testbench

- Upstream sequencer that accepts one 8-bit word per valid/ready handshake and streams it out bit-by-bit.
- Drives a 3-bit select that walks through all eight bit positions, one per accepted serial beat.
- Selects the current bit through the team's `mux8x1` 8:1 gate-level mux.
- Sits between a parallel word source and any bit-serial consumer (shift link, LED/serial pin driver).

---
 rtl/par2ser_pkg.sv | 20 ++
 rtl/par2ser_mux_ctrl_mux8x1.sv | 22 ++
 rtl/par2ser_mux_ctrl.sv | 83 ++++++++
 tb/tb_par2ser_mux_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/par2ser_pkg.sv
// Shared types and constants for the parallel-to-serial sequencer.
package par2ser_pkg;

  localparam int unsigned SEL_W  = 3;
  localparam int unsigned WORD_W = 8;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  function automatic logic [SEL_W-1:0] sel_start(input bit lsb_first);
    return lsb_first ? '0 : '1;
  endfunction

  function automatic logic [SEL_W-1:0] sel_end(input bit lsb_first);
    return lsb_first ? '1 : '0;
  endfunction

endpackage

// File: rtl/par2ser_mux_ctrl_mux8x1.sv
// 8:1 gate-level multiplexer: y = i[s], built from decoded AND terms and an OR tree.
module mux8x1 (
  input  logic [7:0] i,
  input  logic [2:0] s,
  output logic       y
);

  logic [2:0] sn;
  logic [7:0] t;

  assign sn   = ~s;
  assign t[0] = i[0] & sn[2] & sn[1] & sn[0];
  assign t[1] = i[1] & sn[2] & sn[1] & s[0];
  assign t[2] = i[2] & sn[2] & s[1]  & sn[0];
  assign t[3] = i[3] & sn[2] & s[1]  & s[0];
  assign t[4] = i[4] & s[2]  & sn[1] & sn[0];
  assign t[5] = i[5] & s[2]  & sn[1] & s[0];
  assign t[6] = i[6] & s[2]  & s[1]  & sn[0];
  assign t[7] = i[7] & s[2]  & s[1]  & s[0];
  assign y    = |t;

endmodule

// File: rtl/par2ser_mux_ctrl.sv
// Accepts 8-bit words on a valid/ready handshake and streams them out one bit
// per serial beat, walking the mux select from START to END.
module par2ser_mux_ctrl
  import par2ser_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [SEL_W-1:0]  sel,
  output logic              ser_out,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              ser_last
);

  localparam logic [SEL_W-1:0] START = sel_start(LSB_FIRST);
  localparam logic [SEL_W-1:0] END   = sel_end(LSB_FIRST);

  state_t             state_q, state_d;
  logic [WORD_W-1:0]  hold_q, hold_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               beat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      sel_q   <= START;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    sel_d     = sel_q;
    ser_valid = (state_q == SEND);
    ser_last  = ser_valid && (sel_q == END);
    beat      = ser_valid && ser_ready;
    // Gated by rst_n so in_ready reads 0 while reset is held.
    in_ready  = rst_n && ((state_q == IDLE) || (ser_last && ser_ready));

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          hold_d  = in_data;
          sel_d   = START;
          state_d = SEND;
        end
      end
      SEND: begin
        if (beat) begin
          if (!ser_last) begin
            sel_d = LSB_FIRST ? sel_q + SEL_W'(1) : sel_q - SEL_W'(1);
          end else if (in_valid) begin
            hold_d = in_data;
            sel_d  = START;
          end else begin
            sel_d   = START;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sel = sel_q;

  mux8x1 u_mux (
    .i (hold_q),
    .s (sel_q),
    .y (ser_out)
  );

endmodule

// File: tb/tb_par2ser_mux_ctrl.sv
// Scoreboard bench for par2ser_mux_ctrl: one LSB-first and one MSB-first instance share stimulus.
module tb_par2ser_mux_ctrl;

  typedef struct packed {
    logic [2:0] sel;
    logic       b;
    logic       last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       ser_ready = 1'b0;

  logic       in_ready_l, ser_out_l, ser_valid_l, ser_last_l;
  logic [2:0] sel_l;
  logic       in_ready_m, ser_out_m, ser_valid_m, ser_last_m;
  logic [2:0] sel_m;

  par2ser_mux_ctrl #(.LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_l), .sel(sel_l), .ser_out(ser_out_l),
    .ser_valid(ser_valid_l), .ser_ready(ser_ready), .ser_last(ser_last_l)
  );

  par2ser_mux_ctrl #(.LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_m), .sel(sel_m), .ser_out(ser_out_m),
    .ser_valid(ser_valid_m), .ser_ready(ser_ready), .ser_last(ser_last_m)
  );

  always #5 clk = ~clk;

  beat_t       q_l[$];
  beat_t       q_m[$];
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  logic        acc_s = 1'b0;
  logic        beat_s = 1'b0;
  logic [7:0]  data_s = '0;
  logic        rdy_exp_l, rdy_exp_m;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: a word becomes eight beats in the order the select is meant to visit.
  task automatic push_word(input logic [7:0] w);
    for (int k = 0; k < 8; k++) begin
      beat_t bl, bm;
      bl.sel = 3'(k);      bl.b = w[k];     bl.last = (k == 7);
      bm.sel = 3'(7 - k);  bm.b = w[7 - k]; bm.last = (k == 7);
      q_l.push_back(bl);
      q_m.push_back(bm);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready_l"},  in_ready_l,  8'd0);
    check({tag, "_ser_valid_l"}, ser_valid_l, 8'd0);
    check({tag, "_ser_last_l"},  ser_last_l,  8'd0);
    check({tag, "_ser_out_l"},   ser_out_l,   8'd0);
    check({tag, "_sel_l"},       sel_l,       8'd0);
    check({tag, "_in_ready_m"},  in_ready_m,  8'd0);
    check({tag, "_ser_valid_m"}, ser_valid_m, 8'd0);
    check({tag, "_ser_out_m"},   ser_out_m,   8'd0);
    check({tag, "_sel_m"},       sel_m,       8'd7);
  endtask

  // Monitor: compares DUT outputs with the queue head mid-cycle and samples handshakes.
  always @(negedge clk) begin
    if (!rst_n) begin
      check_reset_outputs("rst");
      acc_s  = 1'b0;
      beat_s = 1'b0;
    end else begin
      rdy_exp_l = (q_l.size() == 0) || (q_l[0].last && ser_ready);
      rdy_exp_m = (q_m.size() == 0) || (q_m[0].last && ser_ready);
      check("in_ready_l",  in_ready_l,  rdy_exp_l);
      check("in_ready_m",  in_ready_m,  rdy_exp_m);
      check("ser_valid_l", ser_valid_l, q_l.size() != 0);
      check("ser_valid_m", ser_valid_m, q_m.size() != 0);
      if (q_l.size() != 0) begin
        check("sel_l",      sel_l,      q_l[0].sel);
        check("ser_out_l",  ser_out_l,  q_l[0].b);
        check("ser_last_l", ser_last_l, q_l[0].last);
      end else begin
        check("idle_sel_l",  sel_l,      8'd0);
        check("idle_last_l", ser_last_l, 8'd0);
      end
      if (q_m.size() != 0) begin
        check("sel_m",      sel_m,      q_m[0].sel);
        check("ser_out_m",  ser_out_m,  q_m[0].b);
        check("ser_last_m", ser_last_m, q_m[0].last);
      end else begin
        check("idle_sel_m",  sel_m,      8'd7);
        check("idle_last_m", ser_last_m, 8'd0);
      end
      acc_s  = in_valid && rdy_exp_l;
      beat_s = (q_l.size() != 0) && ser_ready;
      data_s = in_data;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_l.delete();
      q_m.delete();
    end else begin
      if (beat_s && q_l.size() != 0) begin
        void'(q_l.pop_front());
        void'(q_m.pop_front());
      end
      if (acc_s) push_word(data_s);
    end
  end

  task automatic send_word(input logic [7:0] w);
    int unsigned n = 0;
    in_valid = 1'b1;
    in_data  = w;
    do begin
      @(posedge clk);
      n++;
    end while (!acc_s && n < 64);
    if (!acc_s) begin
      n_checks++;
      $display("FAIL accept_timeout: word %0h not accepted within 64 cycles", w);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rise_in_ready_l", in_ready_l, 8'd1);
    check("rise_ser_valid_l", ser_valid_l, 8'd0);
    ser_ready = 1'b1;

    send_word(8'hA5);
    idle_cycles(10);
    send_word(8'h81);
    idle_cycles(10);

    send_word(8'hFF);
    send_word(8'h00);
    idle_cycles(10);

    send_word(8'h3C);
    repeat (4) @(posedge clk);
    #1 ser_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 ser_ready = 1'b1;
    idle_cycles(10);

    send_word(8'hC3);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_word(8'h5A);
    idle_cycles(10);

    for (int c = 0; c < 500; c++) begin
      @(posedge clk);
      #1;
      rst_n     = ($urandom_range(0, 149) != 0);
      in_valid  = $urandom_range(0, 1);
      in_data   = 8'($urandom);
      ser_ready = ($urandom_range(0, 3) != 0);
    end

    #1;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    ser_ready = 1'b1;
    for (int c = 0; c < 40 && q_l.size() != 0; c++) @(posedge clk);
    if (q_l.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d beats still pending", q_l.size());
    end
    idle_cycles(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
